// File: rtl/ttl_74x169_pkg.sv
// Shared constants and operation encoding for the 74x169 up/down counter.
// The counter width is fixed by the TTL part being modelled.
package ttl_74x169_pkg;

  localparam int COUNTER_WIDTH = 4;

  localparam logic [COUNTER_WIDTH-1:0] TC_UP   = 4'hF;
  localparam logic [COUNTER_WIDTH-1:0] TC_DOWN = 4'h0;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } count_op_e;

  // Load beats counting; counting needs both active-low enables asserted.
  function automatic count_op_e decode_op(input logic load, input logic ent, input logic enp);
    if (!load)
      return OP_LOAD;
    else if (!ent && !enp)
      return OP_COUNT;
    else
      return OP_HOLD;
  endfunction

endpackage

// File: rtl/ttl_74x169.sv
// Synchronous 4-bit loadable up/down counter with active-low enables and an
// active-low ripple-carry output for cascading stages.
module ttl_74x169
  import ttl_74x169_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     ud,
  input  logic                     ent,
  input  logic                     enp,
  input  logic [COUNTER_WIDTH-1:0] d,
  output logic                     rco,
  output logic [COUNTER_WIDTH-1:0] q
);

  count_op_e                op;
  logic [COUNTER_WIDTH-1:0] terminal_count;

  assign op = decode_op(load, ent, enp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      unique case (op)
        OP_LOAD:  q <= d;
        OP_COUNT: q <= ud ? q + COUNTER_WIDTH'(1) : q - COUNTER_WIDTH'(1);
        default:  q <= q;
      endcase
    end
  end

  // Combinational so the next stage's ent sees the carry before the shared edge.
  assign terminal_count = ud ? TC_UP : TC_DOWN;
  assign rco            = ~(~ent && (q == terminal_count));

endmodule

// File: tb/tb_ttl_74x169.sv
// Self-checking bench for ttl_74x169: directed walk through the datasheet
// behaviour followed by randomized traffic against an arithmetic model.
module tb_ttl_74x169;

  logic       clock;
  logic       reset;
  logic       load;
  logic       ud;
  logic       ent;
  logic       enp;
  logic [3:0] d;
  logic       rco;
  logic [3:0] q;

  int n_checks;
  int n_fail;
  int model_q;

  ttl_74x169 dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .ud    (ud),
    .ent   (ent),
    .enp   (enp),
    .d     (d),
    .rco   (rco),
    .q     (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic model_rco();
    if (ent == 1'b0 && ((ud && model_q == 15) || (!ud && model_q == 0)))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input logic l, input logic u, input logic et, input logic ep, input logic [3:0] dd);
    load = l;
    ud   = u;
    ent  = et;
    enp  = ep;
    d    = dd;
  endtask

  // Advance one edge, update the model from the held inputs, then check.
  task automatic tick(input string tag);
    @(posedge clock);
    if (!load)
      model_q = int'(d);
    else if (!ent && !enp)
      model_q = ud ? (model_q + 1) % 16 : (model_q + 15) % 16;
    #1;
    check({tag, "_q"}, 32'(q), 32'(model_q));
    check({tag, "_rco"}, 32'(rco), 32'(model_rco()));
  endtask

  task automatic check_q_exp(input string tag, input int exp_q, input logic exp_rco);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_rco"}, 32'(rco), 32'(exp_rco));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_q  = 0;
    reset    = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    #2;
    check_q_exp("reset_ent0_down", 0, 1'b0);
    ud = 1'b1;
    #1;
    check("reset_up_rco", 32'(rco), 32'd1);
    ud = 1'b0;
    ent = 1'b1;
    #1;
    check("reset_ent1_rco", 32'(rco), 32'd1);
    reset = 1'b0;

    // Parallel load then hold.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1101);
    tick("load");
    check_q_exp("load_abs", 13, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    tick("hold_after_load");

    // Up count through the wrap.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    tick("up_e");
    tick("up_f");
    check_q_exp("up_f_abs", 15, 1'b0);
    tick("up_0");
    check_q_exp("up_0_abs", 0, 1'b1);
    tick("up_1");
    tick("up_2");
    check_q_exp("up_2_abs", 2, 1'b1);

    // Enable gating.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 4'h0);
      tick("gate_both_off");
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    tick("gate_enp_off");
    check_q_exp("gate_abs", 2, 1'b1);

    // Down count through the wrap.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick("dn_1");
    tick("dn_0");
    check_q_exp("dn_0_abs", 0, 1'b0);
    tick("dn_f");
    check_q_exp("dn_f_abs", 15, 1'b1);
    tick("dn_e");
    tick("dn_d");
    check_q_exp("dn_d_abs", 13, 1'b1);

    // rco gating at q=1111 going up.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    tick("load_f");
    ent = 1'b0;
    #1;
    check("rco_ent0", 32'(rco), 32'd0);
    enp = 1'b0;
    #1;
    check("rco_enp_toggle", 32'(rco), 32'd0);
    enp = 1'b1;
    ent = 1'b1;
    #1;
    check("rco_ent1", 32'(rco), 32'd1);
    ent = 1'b0;
    ud  = 1'b0;
    #1;
    check("rco_ud_switch", 32'(rco), 32'd1);

    // Async reset mid-count.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h6);
    tick("load_6");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    model_q = 0;
    check("async_reset_q", 32'(q), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
    #1;
    reset = 1'b0;
    tick("post_reset_load");
    check_q_exp("post_reset_abs", 10, 1'b1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)));
      #1;
      check("rnd_rco_comb", 32'(rco), 32'(model_rco()));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        #1;
        model_q = 0;
        check("rnd_async_reset", 32'(q), 32'd0);
        reset = 1'b0;
      end
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
